line_buffer_3row: RTL and testbench

Upstream row generator for the 3x3 Gaussian window stage. Takes a raster-order pixel stream, one pixel per valid cycle, and delays it through two single-line buffers. It then presents three vertically aligned pixels (row r-2, r-1, r) on one cycle. Its outputs drive the window stage's din1/din2/din3 and valid_in directly.

---
 rtl/line_buf_pkg.sv | 13 +
 rtl/line_delay.sv | 30 +++
 rtl/line_buffer_3row.sv | 121 ++++++++++++
 tb/tb_line_buffer_3row.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// Shared constants for the 3-row line buffer.
//   PIX_W       : default pixel width
//   COL_W/ROW_W : column / row counter widths
//   ROWS_NEEDED : rows that must be buffered before a full column is available
package line_buf_pkg;

    localparam int PIX_W = 8;
    localparam int COL_W = 11;
    localparam int ROW_W = 11;

    localparam logic [ROW_W-1:0] ROWS_NEEDED = 11'd2;

endpackage

// File: rtl/line_delay.sv
// Single-line delay RAM, read-before-write.
//   clk   : write clock
//   we    : write enable, commits wdata at addr on the rising edge
//   addr  : shared read/write address
//   wdata : data to store
//   rdata : combinational read of the entry before this cycle's write
// Storage is not reset; the consumer masks stale lines.
module line_delay #(
    parameter int DEPTH = 250,
    parameter int WIDTH = 8,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/line_buffer_3row.sv
// Row generator feeding the 3x3 Gaussian window stage. Delays a raster pixel
// stream through two line buffers and presents rows r-2, r-1 and r of the
// same column together.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   valid_in  : din carries a pixel this cycle
//   sof       : start of frame, qualified by valid_in; forces row 0, col 0
//   din       : pixel input, raster order
//   valid_out : dout1..dout3 form a valid column
//   dout1     : row r-2 (top)
//   dout2     : row r-1 (middle)
//   dout3     : row r, registered din (bottom)
// Optional feature macro LINE_BUF_TOPEDGE_EN: replicate the top edge so rows
// 0 and 1 also produce output columns.
module line_buffer_3row
    import line_buf_pkg::*;
#(
    parameter logic [COL_W-1:0] PIC_WIDTH  = 11'd250,
    parameter logic [ROW_W-1:0] PIC_HEIGHT = 11'd250,
    parameter int               WIDTH      = PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             sof,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3
);

    localparam int DEPTH  = int'(PIC_WIDTH);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] pix_col;
    logic [ROW_W-1:0] pix_row;
    logic             take_sof;
    logic             last_col;
    logic             last_row;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] nxt_dout1;
    logic [WIDTH-1:0] nxt_dout2;
    logic             nxt_valid;

    // A qualified sof restarts the frame on this very pixel, so the buffers
    // and the row test must see position (0,0) rather than the counters.
    assign take_sof = valid_in & sof;
    assign pix_col  = take_sof ? '0 : col;
    assign pix_row  = take_sof ? '0 : row;
    assign last_col = (pix_col == PIC_WIDTH  - 11'd1);
    assign last_row = (pix_row == PIC_HEIGHT - 11'd1);

    line_delay #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_buf_a (
        .clk   (clk),
        .we    (valid_in),
        .addr  (pix_col[ADDR_W-1:0]),
        .wdata (din),
        .rdata (a)
    );

    line_delay #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_buf_b (
        .clk   (clk),
        .we    (valid_in),
        .addr  (pix_col[ADDR_W-1:0]),
        .wdata (a),
        .rdata (b)
    );

    always_comb begin
        nxt_dout1 = b;
        nxt_dout2 = a;
        nxt_valid = (pix_row >= ROWS_NEEDED);
`ifdef LINE_BUF_TOPEDGE_EN
        // Missing rows above the image are filled with the topmost real row.
        nxt_valid = 1'b1;
        if (pix_row == '0) begin
            nxt_dout1 = din;
            nxt_dout2 = din;
        end else if (pix_row == 11'd1) begin
            nxt_dout1 = a;
            nxt_dout2 = a;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            valid_out <= 1'b0;
            dout1     <= '0;
            dout2     <= '0;
            dout3     <= '0;
        end else if (valid_in) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : pix_row + 11'd1;
            end else begin
                col <= pix_col + 11'd1;
                row <= pix_row;
            end
            valid_out <= nxt_valid;
            dout1     <= nxt_dout1;
            dout2     <= nxt_dout2;
            dout3     <= din;
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_buffer_3row.sv
module tb_line_buffer_3row;

    localparam logic [10:0] PW = 11'd4;
    localparam logic [10:0] PH = 11'd4;
`ifdef LINE_BUF_TOPEDGE_EN
    localparam int EXP_VALID = 16;
`else
    localparam int EXP_VALID = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_in;
    logic       sof;
    logic [7:0] din;
    logic       valid_out;
    logic [7:0] dout1, dout2, dout3;

    int n_checks = 0;
    int n_pass   = 0;

    line_buffer_3row #(
        .PIC_WIDTH  (PW),
        .PIC_HEIGHT (PH),
        .WIDTH      (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .sof       (sof),
        .din       (din),
        .valid_out (valid_out),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3)
    );

    always #5 clk = ~clk;

    // Reference model: image position plus, per column, the two most recent
    // pixels seen in that column (i.e. the pixels one and two lines above).
    int         m_row = 0, m_col = 0;
    logic [7:0] above1 [4];
    logic [7:0] above2 [4];
    int         seen   [4];
    logic       e_v = 1'b0, e_k12 = 1'b1;
    logic [7:0] e1 = 8'h00, e2 = 8'h00, e3 = 8'h00;

    initial for (int i = 0; i < 4; i++) seen[i] = 0;

    task automatic model_reset();
        m_row = 0; m_col = 0;
        e_v = 1'b0; e_k12 = 1'b1;
        e1 = 8'h00; e2 = 8'h00; e3 = 8'h00;
    endtask

    // Drives one cycle, updates the model, and returns 1 ns after the edge.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        valid_in = v; sof = s; din = d;
        if (v) begin
            if (s) begin m_row = 0; m_col = 0; end
            e3 = d;
`ifdef LINE_BUF_TOPEDGE_EN
            e_v = 1'b1;
            if (m_row == 0) begin
                e1 = d; e2 = d; e_k12 = 1'b1;
            end else if (m_row == 1) begin
                e1 = above1[m_col]; e2 = above1[m_col]; e_k12 = (seen[m_col] >= 1);
            end else begin
                e1 = above2[m_col]; e2 = above1[m_col]; e_k12 = (seen[m_col] >= 2);
            end
`else
            e_v = (m_row >= 2);
            e1 = above2[m_col]; e2 = above1[m_col]; e_k12 = (seen[m_col] >= 2);
`endif
            above2[m_col] = above1[m_col];
            above1[m_col] = d;
            if (seen[m_col] < 2) seen[m_col]++;
            m_col++;
            if (m_col == int'(PW)) begin
                m_col = 0;
                m_row++;
                if (m_row == int'(PH)) m_row = 0;
            end
        end else begin
            e_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        valid_in = 1'b0; sof = 1'b0; din = 8'h00;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid_out);
        else n_pass++;
        n_checks++;
        if (dout1 !== 8'h00) $display("FAIL reset_dout1: got %h want 00", dout1);
        else n_pass++;
        n_checks++;
        if (dout2 !== 8'h00) $display("FAIL reset_dout2: got %h want 00", dout2);
        else n_pass++;
        n_checks++;
        if (dout3 !== 8'h00) $display("FAIL reset_dout3: got %h want 00", dout3);
        else n_pass++;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_frame(input bit use_sof, input string name);
        int nv = 0, first = -1, idx = 0;
        logic [23:0] first_d = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, use_sof && r == 0 && c == 0, 8'(16 * r + c));
                n_checks++;
                if (valid_out !== e_v || dout3 !== e3 || (e_k12 && (dout1 !== e1 || dout2 !== e2)))
                    $display("FAIL %s px%0d: got v=%0b %h %h %h want v=%0b %h %h %h",
                             name, idx, valid_out, dout1, dout2, dout3, e_v, e1, e2, e3);
                else n_pass++;
                if (valid_out === 1'b1) begin
                    nv++;
                    if (first < 0) begin first = idx; first_d = {dout1, dout2, dout3}; end
                end
`ifdef LINE_BUF_TOPEDGE_EN
                if (idx == 1) begin
                    n_checks++;
                    if ({dout1, dout2, dout3} !== 24'h010101)
                        $display("FAIL %s_px01: got %h want 010101", name, {dout1, dout2, dout3});
                    else n_pass++;
                end
                if (idx == 5) begin
                    n_checks++;
                    if ({dout1, dout2, dout3} !== 24'h010111)
                        $display("FAIL %s_px11: got %h want 010111", name, {dout1, dout2, dout3});
                    else n_pass++;
                end
`endif
                idx++;
            end
        end
        step(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL %s_tail: got v=%0b want 0", name, valid_out);
        else n_pass++;
        n_checks++;
        if (nv != EXP_VALID) $display("FAIL %s_count: got %0d want %0d", name, nv, EXP_VALID);
        else n_pass++;
`ifndef LINE_BUF_TOPEDGE_EN
        n_checks++;
        if (first != 8 || first_d !== 24'h001020)
            $display("FAIL %s_first: got idx %0d %h want idx 8 001020", name, first, first_d);
        else n_pass++;
`endif
    endtask

    task automatic test_gaps();
        int nv = 0;
        for (int p = 0; p < 16; p++) begin
            for (int g = 0; g < 4; g++) begin
                if (g == 0) step(1'b1, p == 0, 8'(16 * (p / 4) + (p % 4)));
                else step(1'b0, g == 2, 8'($urandom));
                n_checks++;
                if (valid_out !== e_v || dout3 !== e3 || (e_k12 && (dout1 !== e1 || dout2 !== e2)))
                    $display("FAIL gaps p%0d g%0d: got v=%0b %h %h %h want v=%0b %h %h %h",
                             p, g, valid_out, dout1, dout2, dout3, e_v, e1, e2, e3);
                else n_pass++;
                if (valid_out === 1'b1) nv++;
            end
        end
        n_checks++;
        if (nv != EXP_VALID) $display("FAIL gaps_count: got %0d want %0d", nv, EXP_VALID);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nv_top = 0;
        logic [23:0] first_d = '0;
        bit got_first = 0;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 16; p++) begin
                step(1'b1, p == 0, 8'((f == 1 ? 8'h80 : 8'h00) + 16 * (p / 4) + (p % 4)));
                n_checks++;
                if (valid_out !== e_v || dout3 !== e3 || (e_k12 && (dout1 !== e1 || dout2 !== e2)))
                    $display("FAIL b2b f%0d p%0d: got v=%0b %h %h %h want v=%0b %h %h %h",
                             f, p, valid_out, dout1, dout2, dout3, e_v, e1, e2, e3);
                else n_pass++;
                if (f == 1 && p < 8 && valid_out === 1'b1) nv_top++;
                if (f == 1 && p >= 8 && !got_first && valid_out === 1'b1) begin
                    got_first = 1; first_d = {dout1, dout2, dout3};
                end
            end
        end
`ifdef LINE_BUF_TOPEDGE_EN
        n_checks++;
        if (nv_top != 8) $display("FAIL b2b_top_rows: got %0d valid want 8", nv_top);
        else n_pass++;
`else
        n_checks++;
        if (nv_top != 0) $display("FAIL b2b_top_rows: got %0d valid want 0", nv_top);
        else n_pass++;
        n_checks++;
        if (first_d !== 24'h8090A0) $display("FAIL b2b_first: got %h want 8090a0", first_d);
        else n_pass++;
`endif
    endtask

    task automatic test_sof_mid();
        int first = -1;
        for (int p = 0; p < 9; p++) begin
            step(1'b1, p == 0, 8'(16 * (p / 4) + (p % 4)));
            n_checks++;
            if (valid_out !== e_v || dout3 !== e3 || (e_k12 && (dout1 !== e1 || dout2 !== e2)))
                $display("FAIL sof_pre p%0d: got v=%0b %h %h %h want v=%0b %h %h %h",
                         p, valid_out, dout1, dout2, dout3, e_v, e1, e2, e3);
            else n_pass++;
        end
        for (int k = 0; k < 13; k++) begin
            step(1'b1, k == 0, 8'($urandom));
            n_checks++;
            if (valid_out !== e_v || dout3 !== e3 || (e_k12 && (dout1 !== e1 || dout2 !== e2)))
                $display("FAIL sof_mid k%0d: got v=%0b %h %h %h want v=%0b %h %h %h",
                         k, valid_out, dout1, dout2, dout3, e_v, e1, e2, e3);
            else n_pass++;
            if (first < 0 && valid_out === 1'b1) first = k;
        end
`ifdef LINE_BUF_TOPEDGE_EN
        n_checks++;
        if (first != 0) $display("FAIL sof_resume: got k=%0d want 0", first);
        else n_pass++;
`else
        n_checks++;
        if (first != 8) $display("FAIL sof_resume: got k=%0d want 8", first);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 15; p++) begin
            step(1'b1, p == 0, 8'(16 * (p / 4) + (p % 4)));
            n_checks++;
            if (valid_out !== e_v || dout3 !== e3 || (e_k12 && (dout1 !== e1 || dout2 !== e2)))
                $display("FAIL rstmid_pre p%0d: got v=%0b %h %h %h want v=%0b %h %h %h",
                         p, valid_out, dout1, dout2, dout3, e_v, e1, e2, e3);
            else n_pass++;
        end
        valid_in = 1'b0; sof = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({valid_out, dout1, dout2, dout3} !== 25'h0)
            $display("FAIL rstmid_clear: got v=%0b %h %h %h want 0 00 00 00",
                     valid_out, dout1, dout2, dout3);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_frame(1'b0, "restart");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic v;
            v = ($urandom_range(0, 9) < 7);
            step(v, v && ($urandom_range(0, 39) == 0), 8'($urandom));
            n_checks++;
            if (valid_out !== e_v || dout3 !== e3 || (e_k12 && (dout1 !== e1 || dout2 !== e2)))
                $display("FAIL random c%0d: got v=%0b %h %h %h want v=%0b %h %h %h",
                         i, valid_out, dout1, dout2, dout3, e_v, e1, e2, e3);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_frame(1'b1, "frame");
        test_gaps();
        test_back_to_back();
        test_sof_mid();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
